// File: rtl/switch_button_user_logic.sv
// AXI-Lite read-side user logic: synchronized switches, debounced buttons with
// sticky clear-on-read press capture, an interrupt enable and a level interrupt.
module switch_button_user_logic #(
  parameter int SW_WIDTH        = 8,
  parameter int BTN_WIDTH       = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 slv_reg_rden,
  input  logic [2:0]           axi_araddr,
  input  logic                 slv_reg_wren,
  input  logic [2:0]           axi_awaddr,
  input  logic [31:0]          S_AXI_WDATA,
  input  logic [SW_WIDTH-1:0]  SW,
  input  logic [BTN_WIDTH-1:0] BTN,
  output logic [31:0]          reg_data_out,
  output logic                 irq
);

  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0]  sw_meta;
  logic [SW_WIDTH-1:0]  sw_state;
  logic [BTN_WIDTH-1:0] btn_meta;
  logic [BTN_WIDTH-1:0] btn_sync;
  logic [BTN_WIDTH-1:0] btn_state;
  logic [BTN_WIDTH-1:0] btn_state_nxt;
  logic [BTN_WIDTH-1:0] btn_rise;
  logic [BTN_WIDTH-1:0] btn_edge;
  logic [CNT_WIDTH-1:0] db_cnt     [BTN_WIDTH];
  logic [CNT_WIDTH-1:0] db_cnt_nxt [BTN_WIDTH];
  logic                 irq_en;
  logic                 rd_edge;
  logic                 wr_ctrl;
  logic [31:0]          rd_mux;
  logic [31:0]          sw_ext;
  logic [31:0]          btn_ext;
  logic [31:0]          edge_ext;
  logic                 unused_wdata;

  assign unused_wdata = ^S_AXI_WDATA[31:1];

  // A button level is accepted only after DEBOUNCE_CYCLES consecutive cycles
  // of disagreement with the accepted state; any agreement restarts the count.
  always_comb begin
    btn_state_nxt = btn_state;
    for (int i = 0; i < BTN_WIDTH; i++) begin
      db_cnt_nxt[i] = '0;
      if (btn_sync[i] != btn_state[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          btn_state_nxt[i] = btn_sync[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign btn_rise = btn_state_nxt & ~btn_state;
  assign rd_edge  = slv_reg_rden && (axi_araddr == 3'd2);
  assign wr_ctrl  = slv_reg_wren && (axi_awaddr == 3'd3);

  always_comb begin
    sw_ext   = '0;
    btn_ext  = '0;
    edge_ext = '0;
    sw_ext[SW_WIDTH-1:0]    = sw_state;
    btn_ext[BTN_WIDTH-1:0]  = btn_state;
    edge_ext[BTN_WIDTH-1:0] = btn_edge;
    case (axi_araddr)
      3'd0:    rd_mux = sw_ext;
      3'd1:    rd_mux = btn_ext;
      3'd2:    rd_mux = edge_ext;
      3'd3:    rd_mux = {31'd0, irq_en};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      sw_meta      <= '0;
      sw_state     <= '0;
      btn_meta     <= '0;
      btn_sync     <= '0;
      btn_state    <= '0;
      btn_edge     <= '0;
      irq_en       <= 1'b0;
      irq          <= 1'b0;
      reg_data_out <= '0;
      for (int i = 0; i < BTN_WIDTH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sw_meta   <= SW;
      sw_state  <= sw_meta;
      btn_meta  <= BTN;
      btn_sync  <= btn_meta;
      btn_state <= btn_state_nxt;
      for (int i = 0; i < BTN_WIDTH; i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
      end
      // A rise committed in the read cycle survives the clear.
      btn_edge <= (rd_edge ? '0 : btn_edge) | btn_rise;
      irq      <= irq_en & (|btn_edge);
      if (slv_reg_rden) begin
        reg_data_out <= rd_mux;
      end
      if (wr_ctrl) begin
        irq_en <= S_AXI_WDATA[0];
      end
    end
  end

endmodule

// File: tb/tb_switch_button_user_logic.sv
// Bench for switch_button_user_logic: directed vector table, hand sequences for
// debounce/interrupt/collision/reset corners, and random traffic against a model.
module tb_switch_button_user_logic;

  localparam int D = 4;

  logic        clk;
  logic        rstn;
  logic        rden;
  logic [2:0]  araddr;
  logic        wren;
  logic [2:0]  awaddr;
  logic [31:0] wdata;
  logic [7:0]  sw;
  logic [4:0]  btn;
  logic [31:0] reg_data_out;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  switch_button_user_logic #(
    .SW_WIDTH(8), .BTN_WIDTH(5), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(3)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
    .slv_reg_rden(rden), .axi_araddr(araddr),
    .slv_reg_wren(wren), .axi_awaddr(awaddr), .S_AXI_WDATA(wdata),
    .SW(sw), .BTN(btn), .reg_data_out(reg_data_out), .irq(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button flips when its last D synced samples all
  // disagree with the accepted level.
  logic [7:0]  m_sw1, m_sw2;
  logic [4:0]  m_b1, m_b2, m_bstate, m_edge;
  logic        m_irq_en, m_irq;
  logic [31:0] m_rdata;
  logic [4:0]  win[$];

  always @(posedge clk) begin
    logic [4:0] ns;
    logic [4:0] rise;
    bit all_diff;
    if (!rstn) begin
      m_sw1 = 0; m_sw2 = 0; m_b1 = 0; m_b2 = 0;
      m_bstate = 0; m_edge = 0; m_irq_en = 0; m_irq = 0; m_rdata = 0;
      win.delete();
    end else begin
      win.push_back(m_b2);
      if (win.size() > D) void'(win.pop_front());
      ns = m_bstate;
      if (win.size() == D) begin
        for (int i = 0; i < 5; i++) begin
          all_diff = 1;
          foreach (win[k]) if (win[k][i] == m_bstate[i]) all_diff = 0;
          if (all_diff) ns[i] = ~m_bstate[i];
        end
      end
      rise = ns & ~m_bstate;
      if (rden) begin
        case (araddr)
          3'd0: m_rdata = {24'd0, m_sw2};
          3'd1: m_rdata = {27'd0, m_bstate};
          3'd2: m_rdata = {27'd0, m_edge};
          3'd3: m_rdata = {31'd0, m_irq_en};
          default: m_rdata = 32'd0;
        endcase
      end
      m_irq  = m_irq_en & (m_edge != 0);
      m_edge = ((rden && araddr == 3'd2) ? 5'd0 : m_edge) | rise;
      if (wren && awaddr == 3'd3) m_irq_en = wdata[0];
      m_bstate = ns;
      m_sw2 = m_sw1; m_sw1 = sw;
      m_b2  = m_b1;  m_b1  = btn;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rdata", reg_data_out, m_rdata);
      chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  // driver tasks
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    rden = 1'b1; araddr = a;
    @(negedge clk);
    rden = 1'b0;
    d = reg_data_out;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wren = 1'b1; awaddr = a; wdata = d;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] got;
    rd(a, got);
    chk(name, got, exp);
  endtask

  typedef struct {
    bit          is_wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic [4:0]  btn;
    int          pre;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit w, logic [2:0] a, logic [31:0] d, logic [7:0] s,
                              logic [4:0] b, int pre, logic [31:0] e);
    vec_t v;
    v.is_wr = w; v.addr = a; v.wdata = d; v.sw = s; v.btn = b; v.pre = pre; v.exp = e;
    return v;
  endfunction

  initial begin
    logic [4:0] btn_r;
    rstn = 0; rden = 0; araddr = 0; wren = 0; awaddr = 0; wdata = 0;
    sw = 8'hFF; btn = 5'h1F;

    // reset held 3 cycles with all inputs high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", reg_data_out, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk_en = 1;
    rstn = 1; btn = 5'h00;

    tbl.push_back(mk(0, 3'd0, 0, 8'hFF, 5'h00, 3, 32'h000000FF));
    tbl.push_back(mk(0, 3'd0, 0, 8'hA5, 5'h00, 2, 32'h000000A5));
    tbl.push_back(mk(1, 3'd0, 32'hFFFFFFFF, 8'hA5, 5'h00, 0, 0));
    tbl.push_back(mk(1, 3'd5, 32'hFFFFFFFF, 8'hA5, 5'h00, 0, 0));
    tbl.push_back(mk(0, 3'd0, 0, 8'hA5, 5'h00, 0, 32'h000000A5));
    tbl.push_back(mk(0, 3'd5, 0, 8'hA5, 5'h00, 0, 32'h00000000));
    tbl.push_back(mk(0, 3'd3, 0, 8'hA5, 5'h00, 0, 32'h00000000));
    tbl.push_back(mk(0, 3'd4, 0, 8'hA5, 5'h00, 0, 32'h00000000));
    tbl.push_back(mk(0, 3'd7, 0, 8'hA5, 5'h00, 0, 32'h00000000));
    tbl.push_back(mk(1, 3'd3, 32'h00000001, 8'hA5, 5'h00, 0, 0));
    tbl.push_back(mk(0, 3'd3, 0, 8'hA5, 5'h00, 0, 32'h00000001));
    tbl.push_back(mk(1, 3'd3, 32'hFFFFFFFE, 8'hA5, 5'h00, 0, 0));
    tbl.push_back(mk(0, 3'd3, 0, 8'hA5, 5'h00, 0, 32'h00000000));
    tbl.push_back(mk(0, 3'd1, 0, 8'hA5, 5'h01, 10, 32'h00000001));
    tbl.push_back(mk(0, 3'd2, 0, 8'hA5, 5'h01, 0, 32'h00000001));
    tbl.push_back(mk(0, 3'd2, 0, 8'hA5, 5'h01, 0, 32'h00000000));
    tbl.push_back(mk(0, 3'd1, 0, 8'hA5, 5'h00, 10, 32'h00000000));
    tbl.push_back(mk(0, 3'd2, 0, 8'hA5, 5'h00, 0, 32'h00000000));
    tbl.push_back(mk(0, 3'd2, 0, 8'hA5, 5'h04, 10, 32'h00000004));
    tbl.push_back(mk(0, 3'd2, 0, 8'hA5, 5'h04, 0, 32'h00000000));
    tbl.push_back(mk(0, 3'd1, 0, 8'hA5, 5'h04, 0, 32'h00000004));
    tbl.push_back(mk(0, 3'd1, 0, 8'hA5, 5'h00, 10, 32'h00000000));
    tbl.push_back(mk(0, 3'd0, 0, 8'h3C, 5'h00, 2, 32'h0000003C));
    tbl.push_back(mk(0, 3'd0, 0, 8'hC3, 5'h00, 1, 32'h0000003C));
    tbl.push_back(mk(0, 3'd0, 0, 8'hC3, 5'h00, 0, 32'h000000C3));

    foreach (tbl[i]) begin
      sw = tbl[i].sw; btn = tbl[i].btn;
      repeat (tbl[i].pre) @(negedge clk);
      if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].wdata);
      else rd_chk($sformatf("tbl[%0d]", i), tbl[i].addr, tbl[i].exp);
    end

    // glitch one cycle shorter than the debounce window
    btn = 5'h01;
    repeat (D - 1) @(negedge clk);
    btn = 5'h00;
    repeat (10) @(negedge clk);
    rd_chk("glitch_state", 3'd1, 32'd0);
    rd_chk("glitch_edge", 3'd2, 32'd0);

    // interrupt: edge commits 6 edges after the press, irq one edge later
    wr(3'd3, 32'd1);
    btn = 5'h02;
    repeat (6) @(negedge clk);
    chk("irq_before", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    rd_chk("irq_edge_read", 3'd2, 32'h02);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    wr(3'd3, 32'd0);
    btn = 5'h00;
    repeat (10) @(negedge clk);
    btn = 5'h02;
    repeat (12) @(negedge clk);
    chk("irq_disabled", {31'd0, irq}, 32'd0);
    rd_chk("irq_dis_edge", 3'd2, 32'h02);
    btn = 5'h00;
    repeat (10) @(negedge clk);

    // read of idx2 in the exact cycle BTN[3] commits, BTN[0] already pending
    btn = 5'h01;
    repeat (10) @(negedge clk);
    btn = 5'h09;
    repeat (5) @(negedge clk);
    rd_chk("collide_ret", 3'd2, 32'h01);
    rd_chk("collide_after", 3'd2, 32'h08);
    btn = 5'h00;
    repeat (10) @(negedge clk);
    rd_chk("release_no_edge", 3'd2, 32'h00);

    // reset mid-debounce with the button still held
    btn = 5'h04;
    repeat (4) @(negedge clk);
    rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    rd_chk("requal_early", 3'd1, 32'h00);
    repeat (8) @(negedge clk);
    rd_chk("requal_state", 3'd1, 32'h04);
    rd_chk("requal_edge", 3'd2, 32'h04);
    btn = 5'h00;
    repeat (10) @(negedge clk);

    // random traffic checked by the model every cycle
    btn_r = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) btn_r = btn_r ^ 5'(1 << $urandom_range(0, 4));
      btn    = btn_r;
      sw     = 8'($urandom);
      rden   = ($urandom_range(0, 2) == 0);
      araddr = 3'($urandom_range(0, 7));
      wren   = ($urandom_range(0, 3) == 0);
      awaddr = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      wdata  = $urandom;
      rstn   = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    rden = 0; wren = 0; rstn = 1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/switch_button_user_logic.md
Name: switch_button_user_logic

Overview:
AXI-Lite read-side user logic, the input counterpart to the LED write path. Samples board switches and push-buttons, synchronizes them to S_AXI_ACLK, debounces the buttons, and captures button press events into sticky bits. Returns the values to the AXI slave read mux via a registered read-data port. Raises a level interrupt on captured presses when enabled.

Parameters:
SW_WIDTH, 8, number of slide switches (1..32)
BTN_WIDTH, 5, number of push-buttons (1..32)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level change (>=2)
CNT_WIDTH, 20, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES

Ports:
S_AXI_ACLK  in  1  system clock
S_AXI_ARESETN  in  1  synchronous active-low reset
slv_reg_rden  in  1  one-cycle read strobe from the AXI slave
axi_araddr  in  3  register index of the read
slv_reg_wren  in  1  one-cycle write strobe from the AXI slave
axi_awaddr  in  3  register index of the write
S_AXI_WDATA  in  32  write data
SW  in  SW_WIDTH  asynchronous switch inputs
BTN  in  BTN_WIDTH  asynchronous button inputs, active-high
reg_data_out  out  32  registered read data
irq  out  1  level interrupt, active-high

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. S_AXI_ARESETN is synchronous and active-low; all state is sampled on the rising edge of S_AXI_ACLK.
- Reset: all sync flops, debounce counters, btn_state, btn_edge, irq_en, reg_data_out and irq go to 0.
- Synchronization: SW and BTN each pass through a 2-flop synchronizer. sw_state is the second flop, so SW is visible in sw_state 2 cycles after the change.
- Debounce, per button, independent:
  - If the synced value equals btn_state, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the synced value still differs, btn_state takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_state.
- Edge capture: a btn_state 0->1 transition sets btn_edge[i]. Bits are sticky until cleared.
- Register map, reads (unused upper bits read 0):
  - idx 0: sw_state (RO)
  - idx 1: btn_state (RO)
  - idx 2: btn_edge (RO, clear-on-read)
  - idx 3: irq_en in bit 0 (RW)
  - idx 4..7: read 0x00000000
- Writes: only idx 3 is writable. On slv_reg_wren && axi_awaddr==3, irq_en <= S_AXI_WDATA[0]. Writes to any other index are ignored.
- Read timing:
  - On slv_reg_rden, reg_data_out is loaded on the next edge with the value of the addressed register in the strobe cycle.
  - reg_data_out holds its value when slv_reg_rden is low.
- Clear-on-read:
  - A read of idx 2 clears btn_edge on the same edge that loads reg_data_out.
  - A new rise in the same cycle wins over the clear: that bit is loaded as 1.
  - The returned value does not include that same-cycle rise.
- irq: registered. irq <= irq_en & |btn_edge, so it follows its inputs by 1 cycle.
- Simultaneous read and write are allowed. A read of idx 3 in the cycle of a write to idx 3 returns the old irq_en.
- Reset mid-debounce discards the count. Buttons still held after reset release must re-qualify for a full DEBOUNCE_CYCLES before they set btn_state and btn_edge.

Test Plan:
Use DEBOUNCE_CYCLES=4 throughout.
1. Reset: hold ARESETN=0 for 3 cycles with SW=0xFF and BTN=0x1F -> reg_data_out=0 and irq=0; after release, a read of idx0 issued 3 or more cycles later returns 0x000000FF.
2. Debounce: BTN[0] high for 3 cycles, then low -> idx1 reads 0 and idx2 reads 0; BTN[0] held high for 10 cycles -> idx1=0x01 and idx2=0x01.
3. Clear-on-read: after a BTN[2] press, read idx2 -> 0x04; next read of idx2 -> 0x00; idx1 still 0x04 while held.
4. Interrupt: write idx3=0x1, then press BTN[1] -> irq=1 one cycle after btn_edge sets; read idx2 -> irq=0 two cycles after the read strobe; with idx3=0x0, a press leaves irq=0.
5. Collision: issue a read strobe of idx2 in the exact cycle BTN[3]'s btn_state rises, with BTN[0] edge already pending -> returned 0x01; btn_edge afterwards=0x08.
6. Unmapped/ignored: write 0xFFFFFFFF to idx0 and idx5 -> idx0 still reflects SW; read idx5 -> 0x00000000; idx3 reads 0x00000000.
